// File: rtl/bank_burst_reader.sv
// Drains one bank of the banked FIFO (2^(N-1) words) as an atomic valid/ready burst with an end marker.
// Optional feature macro: BANK_BURST_TRAILER_EN appends a sum-of-data trailer word to every burst.
module bank_burst_reader #(
    parameter int W = 16,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         en,
    input  logic         fifo_ok,
    input  logic         fifo_bank,
    input  logic [W-1:0] fifo_data,
    output logic         fifo_trigger,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         burst_done,
    output logic         bank_err
);

    localparam int BANK_WORDS = 2 ** (N - 1);
    localparam logic [N-1:0] CNT_LAST = N'(BANK_WORDS - 1);
    localparam logic [N-1:0] CNT_FULL = N'(BANK_WORDS);
    localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_TRAILER = 2'd2
    } state_t;

    state_t       state_r;
    logic         rst_meta_r;
    logic         rst_sync_r;
    logic [N-1:0] cnt_r;
    logic         cur_bank_r;
    logic         out_valid_r;
    logic [W-1:0] out_data_r;
    logic         out_last_r;
    logic         burst_done_r;
    logic         bank_err_r;
`ifdef BANK_BURST_TRAILER_EN
    logic [W-1:0] sum_r;
`endif

    logic         sent_all_s;
    logic         hs_s;
    logic         pop_s;

    // Pop whenever the single output slot is free or being emptied this edge
    always_comb begin
        sent_all_s = (cnt_r == CNT_FULL);
        hs_s       = out_valid_r && out_ready;
        pop_s      = (state_r == ST_BURST) && fifo_ok && (!out_valid_r || out_ready) && !sent_all_s;
    end

    // Reset release synchroniser: assertion is immediate, release takes two edges
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= rst_meta_r;
        end
    end

    // Burst FSM with registered output stage
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            cur_bank_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_last_r   <= 1'b0;
            burst_done_r <= 1'b0;
            bank_err_r   <= 1'b0;
`ifdef BANK_BURST_TRAILER_EN
            sum_r        <= '0;
`endif
        end else if (!rst_sync_r) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            burst_done_r <= 1'b0;
        end else begin
            burst_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (en && fifo_ok) begin
                        state_r    <= ST_BURST;
                        cur_bank_r <= fifo_bank;
                        cnt_r      <= '0;
`ifdef BANK_BURST_TRAILER_EN
                        sum_r      <= '0;
`endif
                    end
                end
                ST_BURST: begin
                    if (!sent_all_s && (fifo_bank != cur_bank_r)) begin
                        bank_err_r <= 1'b1;
                    end
                    if (pop_s) begin
                        out_data_r  <= fifo_data;
                        out_valid_r <= 1'b1;
                        cnt_r       <= cnt_r + CNT_ONE;
`ifdef BANK_BURST_TRAILER_EN
                        out_last_r  <= 1'b0;
                        sum_r       <= sum_r + fifo_data;
`else
                        out_last_r  <= (cnt_r == CNT_LAST);
`endif
                    end else if (hs_s) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        if (sent_all_s) begin
`ifdef BANK_BURST_TRAILER_EN
                            // Last data word accepted: present the running sum as the trailer
                            state_r     <= ST_TRAILER;
                            out_data_r  <= sum_r;
                            out_valid_r <= 1'b1;
                            out_last_r  <= 1'b1;
`else
                            state_r      <= ST_IDLE;
                            burst_done_r <= 1'b1;
`endif
                        end
                    end
                end
                ST_TRAILER: begin
`ifdef BANK_BURST_TRAILER_EN
                    if (hs_s) begin
                        out_valid_r  <= 1'b0;
                        out_last_r   <= 1'b0;
                        state_r      <= ST_IDLE;
                        burst_done_r <= 1'b1;
                    end
`else
                    state_r <= ST_IDLE;
`endif
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_trigger = pop_s;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_last     = out_last_r;
    assign burst_done   = burst_done_r;
    assign bank_err     = bank_err_r;

endmodule

// File: tb/tb_bank_burst_reader.sv
// Randomized self-checking bench for bank_burst_reader (N=4, 8-word banks) with a FIFO model.
// Expected bursts are computed from the FIFO contents; BANK_BURST_TRAILER_EN adds the sum trailer.
module tb_bank_burst_reader;

    localparam int W    = 16;
    localparam int N    = 4;
    localparam int BANK = 8;
`ifdef BANK_BURST_TRAILER_EN
    localparam int TRL  = 1;
`else
    localparam int TRL  = 0;
`endif
    localparam int BLEN = BANK + TRL;

    logic         clk = 1'b0;
    logic         rst_ = 1'b0;
    logic         en = 1'b0;
    logic         fifo_ok = 1'b0;
    logic         fifo_bank = 1'b0;
    logic [W-1:0] fifo_data;
    logic         fifo_trigger;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         burst_done;
    logic         bank_err;

    bank_burst_reader #(.W(W), .N(N)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .en           (en),
        .fifo_ok      (fifo_ok),
        .fifo_bank    (fifo_bank),
        .fifo_data    (fifo_data),
        .fifo_trigger (fifo_trigger),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .burst_done   (burst_done),
        .bank_err     (bank_err)
    );

    always #5 clk = ~clk;

    // FIFO model: combinational read data, one pop per edge with fifo_trigger
    logic [W-1:0] mem [0:63];
    logic [5:0]   rd_ptr = 6'd0;
    int           pops = 0;
    assign fifo_data = mem[rd_ptr];
    always @(posedge clk) begin
        if (fifo_trigger === 1'b1) begin
            rd_ptr <= rd_ptr + 6'd1;
            pops   <= pops + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    logic [W-1:0] got_d[$];
    logic         got_l[$];
    logic [W-1:0] exp_d[$];
    logic         exp_l[$];
    int           hs_cyc[$];
    int           cyc = 0;
    int           done_cnt, stall_viol, trig_viol, mid_invalid, pop0;
    bit           prev_stall;
    logic [W-1:0] prev_d;
    logic         prev_l;
    int           en_until, ready_mode, drop_after, ok_low, flip_after;
    bit           dropped;
    bit           ready_seq[$];

    task automatic setup();
        got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
        hs_cyc.delete(); ready_seq.delete();
        done_cnt = 0; stall_viol = 0; trig_viol = 0; mid_invalid = 0;
        prev_stall = 1'b0; pop0 = pops;
        en_until = 1; ready_mode = 0; drop_after = -1; ok_low = 0; flip_after = -1;
        dropped = 1'b0;
        en = 1'b1; fifo_ok = 1'b1; out_ready = 1'b1;
    endtask

    // One clock: drive inputs after the falling edge, then observe what the next rising edge will do
    task automatic cycle();
        @(negedge clk);
        if (drop_after >= 0 && !dropped && (pops - pop0) >= drop_after) begin
            ok_low  = 5;
            dropped = 1'b1;
        end
        if (ok_low > 0) begin
            fifo_ok = 1'b0;
            ok_low--;
        end else begin
            fifo_ok = 1'b1;
        end
        if (ready_seq.size() > 0) out_ready = ready_seq.pop_front();
        else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else out_ready = 1'b1;
        en = (got_d.size() < en_until);
        if (flip_after >= 0 && got_d.size() >= flip_after) fifo_bank = 1'b1;
        #1;
        if (prev_stall && (!out_valid || out_data !== prev_d || out_last !== prev_l)) stall_viol++;
        if (out_valid && !out_ready && fifo_trigger) trig_viol++;
        if (burst_done === 1'b1) done_cnt++;
        if (got_d.size() > 0 && got_d.size() < BANK && !out_valid) mid_invalid++;
        if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
            hs_cyc.push_back(cyc);
        end
        prev_stall = out_valid && !out_ready;
        prev_d = out_data;
        prev_l = out_last;
        cyc++;
    endtask

    task automatic run(input int target);
        int budget;
        budget = 60 * target;
        while (done_cnt < target && budget > 0) begin
            cycle();
            budget--;
        end
    endtask

    // Reference: each burst is the next BANK FIFO words, last flag on the final word, optional sum trailer
    task automatic build_expected(input int start, input int nb);
        logic [W-1:0] sum;
        logic [W-1:0] v;
        for (int b = 0; b < nb; b++) begin
            sum = '0;
            for (int i = 0; i < BANK; i++) begin
                v = mem[(start + b * BANK + i) % 64];
                exp_d.push_back(v);
                exp_l.push_back((TRL == 0) && (i == BANK - 1));
                sum = sum + v;
            end
            if (TRL == 1) begin
                exp_d.push_back(sum);
                exp_l.push_back(1'b1);
            end
        end
    endtask

    task automatic stream_diff(output int nbad, output int idx);
        int n;
        nbad = 0;
        idx  = -1;
        n = (got_d.size() > exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            if (i >= got_d.size() || i >= exp_d.size() ||
                got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                nbad++;
                if (idx < 0) idx = i;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) mem[i] = W'($urandom);
        en = 1'b1; fifo_ok = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({fifo_trigger, out_valid, out_last, burst_done, bank_err} !== 5'b0 || out_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got trig/valid/last/done/err=%b data=%h, expected 00000 data=0000",
                     {fifo_trigger, out_valid, out_last, burst_done, bank_err}, out_data);
        end
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (fifo_trigger !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_sync: two edges after release trig=%b valid=%b, expected 0 0", fifo_trigger, out_valid);
        end
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int p, nbad, idx;
        p = rd_ptr;
        for (int i = 0; i < 16; i++) mem[(p + i) % 64] = W'(i);
        setup();
        build_expected(p, 1);
        run(1);
        repeat (4) cycle();
        stream_diff(nbad, idx);
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL basic_stream: %0d bad entries, first at %0d, got %0d words, expected %0d", nbad, idx, got_d.size(), exp_d.size());
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL basic_done: got %0d pulses, expected 1", done_cnt); end
        checks++;
        if (pops - pop0 !== BANK) begin errors++; $display("FAIL basic_pops: got %0d pops, expected %0d", pops - pop0, BANK); end
        checks++;
        if (mid_invalid !== 0) begin errors++; $display("FAIL basic_consecutive: got %0d bubbles, expected 0", mid_invalid); end
    endtask

    task automatic test_ready_toggle();
        int p, nbad, idx;
        p = rd_ptr;
        for (int i = 0; i < BANK; i++) mem[(p + i) % 64] = W'($urandom);
        setup();
        ready_mode = 1;
        for (int k = 0; k < 10; k++) begin
            ready_seq.push_back(1'b1); ready_seq.push_back(1'b0);
            ready_seq.push_back(1'b0); ready_seq.push_back(1'b1);
        end
        build_expected(p, 1);
        run(1);
        repeat (3) cycle();
        stream_diff(nbad, idx);
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL stall_stream: %0d bad entries, first at %0d, got %0d words, expected %0d", nbad, idx, got_d.size(), exp_d.size());
        end
        checks++;
        if (stall_viol !== 0) begin errors++; $display("FAIL stall_hold: got %0d changes while stalled, expected 0", stall_viol); end
        checks++;
        if (trig_viol !== 0) begin errors++; $display("FAIL stall_trigger: got %0d pops while stalled, expected 0", trig_viol); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL stall_done: got %0d pulses, expected 1", done_cnt); end
        checks++;
        if (pops - pop0 !== BANK) begin errors++; $display("FAIL stall_pops: got %0d pops, expected %0d", pops - pop0, BANK); end
    endtask

    task automatic test_ok_drop();
        int p, nbad, idx;
        p = rd_ptr;
        for (int i = 0; i < BANK; i++) mem[(p + i) % 64] = W'($urandom);
        setup();
        drop_after = 4;
        build_expected(p, 1);
        run(1);
        repeat (3) cycle();
        stream_diff(nbad, idx);
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL okdrop_stream: %0d bad entries, first at %0d, got %0d words, expected %0d", nbad, idx, got_d.size(), exp_d.size());
        end
        checks++;
        if (mid_invalid < 1) begin errors++; $display("FAIL okdrop_gap: got %0d invalid cycles mid-burst, expected at least 1", mid_invalid); end
        checks++;
        if (pops - pop0 !== BANK) begin errors++; $display("FAIL okdrop_pops: got %0d pops, expected %0d", pops - pop0, BANK); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL okdrop_done: got %0d pulses, expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int p, nbad, idx, budget;
        logic [W-1:0] first_word;
        p = rd_ptr;
        for (int i = 0; i < 32; i++) mem[(p + i) % 64] = W'(i);
        setup();
        budget = 60;
        do begin
            cycle();
            budget--;
        end while (!(out_valid === 1'b1 && out_data === 16'd2) && budget > 0);
        rst_ = 1'b0;
        #1;
        checks++;
        if ({fifo_trigger, out_valid, out_last, burst_done} !== 4'b0 || out_data !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_outputs: got trig/valid/last/done=%b data=%h, expected 0000 data=0000",
                     {fifo_trigger, out_valid, out_last, burst_done}, out_data);
        end
        checks++;
        if (pops - pop0 !== 3) begin errors++; $display("FAIL midreset_pops: got %0d pops before reset, expected 3", pops - pop0); end
        setup();
        build_expected(int'(rd_ptr), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;
        run(1);
        repeat (2) cycle();
        first_word = (got_d.size() > 0) ? got_d[0] : 16'hxxxx;
        checks++;
        if (first_word !== 16'd3) begin errors++; $display("FAIL midreset_first: got %h, expected 0003", first_word); end
        stream_diff(nbad, idx);
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL midreset_stream: %0d bad entries, first at %0d, got %0d words, expected %0d", nbad, idx, got_d.size(), exp_d.size());
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL midreset_done: got %0d pulses, expected 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        int p, nbad, idx, gap;
        p = rd_ptr;
        for (int i = 0; i < 2 * BANK; i++) mem[(p + i) % 64] = W'($urandom);
        setup();
        en_until = BLEN + 1;
        ready_mode = 1;
        build_expected(p, 2);
        run(2);
        repeat (3) cycle();
        stream_diff(nbad, idx);
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL b2b_stream: %0d bad entries, first at %0d, got %0d words, expected %0d", nbad, idx, got_d.size(), exp_d.size());
        end
        checks++;
        if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done: got %0d pulses, expected 2", done_cnt); end
        gap = (hs_cyc.size() > BLEN) ? (hs_cyc[BLEN] - hs_cyc[BLEN - 1]) : -1;
        checks++;
        if (gap < 3) begin errors++; $display("FAIL b2b_gap: got %0d clocks between bursts, expected at least 3", gap); end
        checks++;
        if (pops - pop0 !== 2 * BANK) begin errors++; $display("FAIL b2b_pops: got %0d pops, expected %0d", pops - pop0, 2 * BANK); end
    endtask

    task automatic test_bank_err();
        int p, nbad, idx;
        checks++;
        if (bank_err !== 1'b0) begin errors++; $display("FAIL bankerr_pre: got %b, expected 0", bank_err); end
        p = rd_ptr;
        for (int i = 0; i < BANK; i++) mem[(p + i) % 64] = W'($urandom);
        fifo_bank = 1'b0;
        setup();
        flip_after = 5;
        build_expected(p, 1);
        run(1);
        repeat (2) cycle();
        stream_diff(nbad, idx);
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL bankerr_stream: %0d bad entries, first at %0d, got %0d words, expected %0d", nbad, idx, got_d.size(), exp_d.size());
        end
        checks++;
        if (bank_err !== 1'b1) begin errors++; $display("FAIL bankerr_set: got %b, expected 1", bank_err); end
        fifo_bank = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bank_err !== 1'b1) begin errors++; $display("FAIL bankerr_sticky: got %b, expected 1", bank_err); end
    endtask

    task automatic test_trailer();
        int p, nbad, idx;
        logic [W-1:0] exp_final;
        logic [W-1:0] got_final;
        logic         got_final_l;
        for (int pat = 0; pat < 2; pat++) begin
            p = rd_ptr;
            for (int i = 0; i < BANK; i++) mem[(p + i) % 64] = (pat == 0) ? W'(i + 1) : 16'hFFFF;
            if (TRL == 1) exp_final = (pat == 0) ? 16'h0024 : 16'hFFF8;
            else exp_final = (pat == 0) ? 16'h0008 : 16'hFFFF;
            setup();
            build_expected(p, 1);
            run(1);
            repeat (2) cycle();
            stream_diff(nbad, idx);
            checks++;
            if (nbad !== 0) begin
                errors++;
                $display("FAIL trailer_stream%0d: %0d bad entries, first at %0d, got %0d words, expected %0d", pat, nbad, idx, got_d.size(), exp_d.size());
            end
            got_final   = (got_d.size() > 0) ? got_d[got_d.size() - 1] : 16'hxxxx;
            got_final_l = (got_l.size() > 0) ? got_l[got_l.size() - 1] : 1'bx;
            checks++;
            if (got_final !== exp_final || got_final_l !== 1'b1) begin
                errors++;
                $display("FAIL trailer_final%0d: got %h last=%b, expected %h last=1", pat, got_final, got_final_l, exp_final);
            end
            checks++;
            if (got_d.size() !== BLEN) begin errors++; $display("FAIL trailer_len%0d: got %0d words, expected %0d", pat, got_d.size(), BLEN); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_toggle();
        test_ok_drop();
        test_reset_mid();
        test_back_to_back();
        test_trailer();
        test_bank_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
